// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the memory port arbiter
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational ready selection between fetch and data requesters
module mem_arb_grant (
    input  logic if_valid,
    input  logic dm_valid,
    input  logic idle,
    input  logic prio_dm,
    output logic if_ready,
    output logic dm_ready
);

    // prio_dm decides only on contention; a lone requester is always accepted.
    always_comb begin
        dm_ready = idle & (prio_dm | ~if_valid);
        if_ready = idle & (~prio_dm | ~dm_valid);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store paths
// Optional: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed data priority.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_addr,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req_valid,
    output logic          dm_req_ready,
    input  logic [AW-1:0] dm_addr,
    input  logic          dm_wr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_rsp_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [AW-1:0]         addr_q;
    logic [DW-1:0]         wdata_q;
    logic                  wr_q;
    owner_t                owner_q;
    logic [LAT_CNT_W-1:0]  cnt;
    logic                  idle;
    logic                  prio_dm;
    logic                  if_hs;
    logic                  dm_hs;

    // Readys are held low while reset is asserted so every output reads 0.
    assign idle  = (state == IDLE) & rst_n;
    assign if_hs = if_req_valid & if_req_ready;
    assign dm_hs = dm_req_valid & dm_req_ready;

    mem_arb_grant u_grant (
        .if_valid (if_req_valid),
        .dm_valid (dm_req_valid),
        .idle     (idle),
        .prio_dm  (prio_dm),
        .if_ready (if_req_ready),
        .dm_ready (dm_req_ready)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_dm <= 1'b1;
        end else if (dm_hs) begin
            prio_dm <= 1'b0;
        end else if (if_hs) begin
            prio_dm <= 1'b1;
        end
    end
`else
    assign prio_dm = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_rsp_valid = 1'b0;
        dm_rsp_valid = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (if_hs || dm_hs) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_en     = 1'b1;
                mem_we     = wr_q;
                mem_addr   = addr_q;
                mem_wdata  = wr_q ? wdata_q : '0;
                state_next = wr_q ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == LAT_CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if_rsp_valid = (owner_q == OWN_IF);
                dm_rsp_valid = (owner_q == OWN_DM);
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            owner_q  <= OWN_DM;
            cnt      <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_hs) begin
                        addr_q  <= dm_addr;
                        wdata_q <= dm_wdata;
                        wr_q    <= dm_wr;
                        owner_q <= OWN_DM;
                    end else if (if_hs) begin
                        addr_q  <= if_addr;
                        wdata_q <= '0;
                        wr_q    <= 1'b0;
                        owner_q <= OWN_IF;
                    end
                end
                ACCESS: begin
                    cnt <= LAT_INIT;
                end
                WAIT: begin
                    cnt <= cnt - LAT_CNT_W'(1);
                    // Last wait cycle: read data is valid on the port now.
                    if (cnt == LAT_CNT_W'(1)) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter (MEM_LAT 2 and 4 instances)
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        if_valid, if_ready, if_rsp, dm_valid, dm_ready, dm_wr, dm_rsp;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_if_ready, b_if_rsp, b_dm_valid, b_dm_ready, b_dm_rsp;
    logic [31:0] b_if_rdata, b_dm_addr, b_dm_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [31:0] pa0 = '0, pa1 = '0;
    logic [31:0] pb [4] = '{default: '0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Memory models: data appears exactly MEM_LAT cycles after the enable cycle.
    always @(posedge clk) begin
        pa0 <= (mem_en && !mem_we) ? mdata(mem_addr) : 32'h0;
        pa1 <= pa0;
        pb[0] <= (b_mem_en && !b_mem_we) ? mdata(b_mem_addr) : 32'h0;
        for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
    end
    assign mem_rdata   = pa1;
    assign b_mem_rdata = pb[3];

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_valid), .if_req_ready(if_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp), .if_rdata(if_rdata),
        .dm_req_valid(dm_valid), .dm_req_ready(dm_ready), .dm_addr(dm_addr),
        .dm_wr(dm_wr), .dm_wdata(dm_wdata), .dm_rsp_valid(dm_rsp), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(1'b0), .if_req_ready(b_if_ready), .if_addr(32'h0),
        .if_rsp_valid(b_if_rsp), .if_rdata(b_if_rdata),
        .dm_req_valid(b_dm_valid), .dm_req_ready(b_dm_ready), .dm_addr(b_dm_addr),
        .dm_wr(1'b0), .dm_wdata(32'h0), .dm_rsp_valid(b_dm_rsp), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy || b_busy) && n < 50) begin
            step();
            n++;
        end
        chk(tag, 32'(busy | b_busy), 32'h0);
    endtask

    initial begin
        int ng;
        int t0;
        int g [3];
        int en_cnt;
        int rsp_cnt;
        logic saw_if_ready;
        logic saw_rsp;
        logic [1:0] own [6];
        logic [1:0] exp_own;

        if_valid = 0; if_addr = 0; dm_valid = 0; dm_addr = 0; dm_wr = 0; dm_wdata = 0;
        b_dm_valid = 0; b_dm_addr = 0;

        // Reset: every output low, readys included.
        step(); step();
        chk("rst_dm_ready", 32'(dm_ready), 0);
        chk("rst_if_ready", 32'(if_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk); rst_n = 1; #1;
        chk("idle_dm_ready", 32'(dm_ready), 1);
        chk("idle_if_ready", 32'(if_ready), 1);
        chk("idle_mem_en", 32'(mem_en), 0);
        chk("idle_if_rdata", if_rdata, 0);

        // Lone fetch, MEM_LAT=2: mem_en T+1, rsp T+4.
        if_valid = 1; if_addr = 32'h40; #1;
        chk("f_if_ready_T", 32'(if_ready), 1);
        step(); if_valid = 0; if_addr = 32'h0; #1;
        chk("f_mem_en_T1", 32'(mem_en), 1);
        chk("f_mem_we_T1", 32'(mem_we), 0);
        chk("f_mem_addr_T1", mem_addr, 32'h40);
        chk("f_busy_T1", 32'(busy), 1);
        chk("f_if_ready_T1", 32'(if_ready), 0);
        step();
        chk("f_mem_en_T2", 32'(mem_en), 0);
        chk("f_mem_addr_T2", mem_addr, 0);
        step();
        chk("f_rsp_T3", 32'(if_rsp), 0);
        step();
        chk("f_if_rsp_T4", 32'(if_rsp), 1);
        chk("f_if_rdata_T4", if_rdata, 32'hDEADBEEF);
        chk("f_dm_rsp_T4", 32'(dm_rsp), 0);
        step();
        chk("f_if_rsp_T5", 32'(if_rsp), 0);
        chk("f_busy_T5", 32'(busy), 0);
        chk("f_if_rdata_hold", if_rdata, 32'hDEADBEEF);

        // Lone store: mem_en/we T+1, dm_rsp T+2, accept again T+3.
        dm_valid = 1; dm_wr = 1; dm_addr = 32'h100; dm_wdata = 32'h12345678; #1;
        chk("s_dm_ready_T", 32'(dm_ready), 1);
        step(); dm_valid = 0; dm_wr = 0; #1;
        chk("s_mem_en_T1", 32'(mem_en), 1);
        chk("s_mem_we_T1", 32'(mem_we), 1);
        chk("s_mem_addr_T1", mem_addr, 32'h100);
        chk("s_mem_wdata_T1", mem_wdata, 32'h12345678);
        step();
        chk("s_dm_rsp_T2", 32'(dm_rsp), 1);
        chk("s_if_rsp_T2", 32'(if_rsp), 0);
        chk("s_dm_rdata_T2", dm_rdata, 0);
        chk("s_mem_wdata_T2", mem_wdata, 0);
        step();
        chk("s_dm_ready_T3", 32'(dm_ready), 1);
        chk("s_busy_T3", 32'(busy), 0);

        // Reset during WAIT of a load.
        if_valid = 1; if_addr = 32'h44;
        step(); if_valid = 0;
        step();
        chk("r_busy_wait", 32'(busy), 1);
        rst_n = 0; #1;
        chk("r_busy", 32'(busy), 0);
        chk("r_mem_en", 32'(mem_en), 0);
        chk("r_if_ready", 32'(if_ready), 0);
        chk("r_if_rdata", if_rdata, 0);
        step(); step();
        rst_n = 1;
        saw_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            saw_rsp = saw_rsp | if_rsp | dm_rsp | busy;
        end
        chk("r_no_rsp_after", 32'(saw_rsp), 0);

        // Contention for six grants.
        if_valid = 1; if_addr = 32'h300; dm_valid = 1; dm_addr = 32'h200; dm_wr = 0; #1;
        ng = 0; t0 = 0; saw_if_ready = 0;
        while (ng < 6 && t0 < 100) begin
            saw_if_ready = saw_if_ready | if_ready;
            if (dm_ready) begin own[ng] = 2'd1; ng++; end
            else if (if_ready) begin own[ng] = 2'd0; ng++; end
            if (ng < 6) begin step(); t0++; end
        end
        chk("c_grant_count", 32'(ng), 6);
        step();
        if_valid = 0; dm_valid = 0;
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_own = (i % 2 == 0) ? 2'd1 : 2'd0;
`else
            exp_own = 2'd1;
`endif
            chk($sformatf("c_grant%0d", i), 32'(own[i]), 32'(exp_own));
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("c_if_ready_seen", 32'(saw_if_ready), 1);
`else
        chk("c_if_ready_seen", 32'(saw_if_ready), 0);
`endif
        drain("c_drain");

        // Payload change while not ready is ignored; accepted address is used.
        dm_valid = 1; dm_wr = 1; dm_addr = 32'h500; dm_wdata = 32'h55;
        if_valid = 1; if_addr = 32'h10; #1;
        chk("p_if_ready_T", 32'(if_ready), 0);
        step(); dm_valid = 0; dm_wr = 0; if_addr = 32'h20;
        t0 = 0; #1;
        while (!if_ready && t0 < 20) begin step(); t0++; end
        chk("p_if_ready_seen", 32'(if_ready), 1);
        step(); if_valid = 0; #1;
        chk("p_mem_en", 32'(mem_en), 1);
        chk("p_mem_addr", mem_addr, 32'h20);
        step(); step(); step();
        chk("p_if_rsp", 32'(if_rsp), 1);
        chk("p_if_rdata", if_rdata, 32'h0020FFDF);

        // MEM_LAT=4 back-to-back loads from DM.
        b_dm_valid = 1; b_dm_addr = 32'h800; #1;
        ng = 0; t0 = 0; en_cnt = 0; rsp_cnt = 0;
        while (ng < 3 && t0 < 100) begin
            if (ng > 0) begin
                en_cnt  += int'(b_mem_en);
                rsp_cnt += int'(b_dm_rsp);
            end
            if (b_dm_ready) begin g[ng] = cyc; ng++; end
            if (ng < 3) begin step(); t0++; end
        end
        chk("b_grant_count", 32'(ng), 3);
        chk("b_period01", 32'(g[1] - g[0]), 7);
        chk("b_period12", 32'(g[2] - g[1]), 7);
        chk("b_mem_en_cnt", 32'(en_cnt), 2);
        chk("b_rsp_cnt", 32'(rsp_cnt), 2);
        step();
        b_dm_valid = 0;
        drain("b_drain");
        chk("b_dm_rdata", b_dm_rdata, 32'h0800F7FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
